pixel_phrase_builder: RTL and testbench
=======================================

// Module: pixel_phrase_builder
// PURPOSE
//  Packs the camera's 16-bit RGB565 pixel stream into 128-bit phrases (8 pixels) for the DDR3 write-path AXIS FIFO.
//  Flags the first phrase of each frame on tuser, so the DDR3 write address realigns to 0 at every frame.
//  Sits between the camera pixel-capture stage and the write AXIS FIFO.
//  Never stalls the camera: phrases that find the output buffer full are dropped and counted.
// PARAMETERS
//  PIXELS_PER_FRAME  1280*720  pixels per frame; must be a multiple of 8
//  DROP_CNT_W        16        width of the saturating dropped-phrase counter
// PORTS
//  clk_in             in   1    camera-domain clock
//  rst_in             in   1    synchronous active-high reset
//  pixel_valid_in     in   1    pixel_data_in valid this cycle
//  pixel_data_in      in   16   RGB565 pixel
//  frame_start_in     in   1    qualified by pixel_valid_in: this pixel is pixel 0 of a frame
//  phrase_axis_data   out  128  packed phrase; pixel k at [16k+15:16k], k=0 is the earliest pixel
//  phrase_axis_tuser  out  1    phrase holds pixel 0 of a frame
//  phrase_axis_valid  out  1    AXIS valid
//  phrase_axis_ready  in   1    AXIS ready from the write FIFO
//  drop_count_out     out  DROP_CNT_W  phrases dropped since reset; saturates at all-ones
//  overflow_out       out  1    sticky; set on the first drop, cleared only by reset
//  state_out          out  2    current FSM state encoding, for debug
// BEHAVIOUR
//  Reset: FSM=WAIT_SOF, slot=0, pix_cnt=0, buffer empty, valid=0, tuser=0, data=0, drop_count=0, overflow=0.
//  FSM states (encoding as listed):
//   WAIT_SOF=0: ignore pixels; on valid&&frame_start -> PACK, pixel stored in slot 0, sof_flag=1.
//   PACK=1: on each valid pixel, store at slot, slot++, pix_cnt++.
//   DONE=2: reached when pix_cnt hits PIXELS_PER_FRAME; ignore pixels until valid&&frame_start, then act as in WAIT_SOF.
//  frame_start in PACK (short frame): discard the partial phrase (no push, no drop count), slot=0, pix_cnt=0, sof_flag=1;
//   the current pixel becomes slot 0.
//  frame_start in PACK with slot==7 pending is not a special case: it takes the short-frame path.
//  8th pixel (slot 7): assemble the phrase with tuser=sof_flag and push it to the buffer; clear sof_flag; slot wraps to 0.
//  Latency: the phrase is presented at phrase_axis_valid the cycle after the 8th pixel, if the buffer was empty.
//  Output buffer: 2-entry FIFO in order; head drives the AXIS outputs directly from registers.
//   A pop occurs when valid&&ready. Data/tuser hold stable while valid&&!ready.
//  Full: a push while occupancy==2 and no pop in the same cycle -> phrase dropped; drop_count++ (saturating); overflow=1.
//   A push while occupancy==2 and a pop in the same cycle is accepted.
//  A dropped phrase that carried tuser loses its SOF marker; the next frame_start restores alignment.
//  pix_cnt width = $clog2(PIXELS_PER_FRAME+1); compare for equality only, no wrap.
//  Reset mid-frame: everything returns to reset values; no partial phrase is emitted.
// CONFIGURATION
//  PPB_TEST_PATTERN_EN defined:
//   - pixel_data_in is ignored.
//   - Each pixel = {c[4:0],c[5:0],c[4:0]} with c = column-in-phrase-group index (pix_cnt>>3)%64.
//   - Timing, framing and handshakes are unchanged.
//  Not defined: camera data is passed through as-is.
// STRUCTURE
//  Package ppb_pkg:
//   - typedef enum logic[1:0] {WAIT_SOF, PACK, DONE} ppb_state_t
//   - PIXEL_W=16, PHRASE_W=128, PIXELS_PER_PHRASE=8
//  Sub-module phrase_skid_fifo: 2-entry FIFO of {tuser, data}.
//   - Ports: push/din/full in, pop/dout/empty out.
//   - Reports the same-cycle pop so the top level can apply the full/drop rule.
// TESTING
//  Single frame, PIXELS_PER_FRAME=32, ready=1:
//   pixels 0x0000..0x001F -> 4 phrases; the first is 0x0007_0006_..._0000 with tuser=1; the rest have tuser=0.
//  Pixels before the first frame_start are ignored:
//   10 junk pixels, then SOF -> the first phrase has tuser=1 and holds only post-SOF pixels.
//  Short frame: SOF, 5 pixels, SOF, 8 pixels -> exactly 1 phrase, tuser=1, drop_count=0.
//  Backpressure: ready=0 for 24 pixels (3 phrases) -> 2 phrases buffered, drop_count=1, overflow=1;
//   release ready -> phrases 0 and 1 drain in order.
//  Push+pop at full: occupancy 2; 8th pixel arrives in the same cycle as a valid&&ready pop -> no drop, occupancy stays 2.
//  DONE: 40 pixels after SOF with PIXELS_PER_FRAME=32 -> 4 phrases only; state_out=2 until the next SOF.
//  Reset asserted mid-phrase -> valid=0, state_out=0; the following SOF frame packs correctly.

Source files
------------

// File: rtl/ppb_pkg.sv
// rtl/ppb_pkg.sv - shared types and widths for the pixel phrase builder
package ppb_pkg;
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PACK     = 2'd1,
    DONE     = 2'd2
  } ppb_state_t;

  localparam int PIXEL_W           = 16;
  localparam int PHRASE_W          = 128;
  localparam int PIXELS_PER_PHRASE = 8;

  // Test-pattern pixel: the group index replicated into R, G and B fields.
  function automatic logic [PIXEL_W-1:0] test_pixel(input logic [5:0] c);
    return {c[4:0], c, c[4:0]};
  endfunction
endpackage

// File: rtl/pixel_phrase_builder_if.sv
// rtl/pixel_phrase_builder_if.sv - AXIS-style phrase output bundle
interface pixel_phrase_builder_if;
  logic [ppb_pkg::PHRASE_W-1:0] phrase_axis_data;
  logic                         phrase_axis_tuser;
  logic                         phrase_axis_valid;
  logic                         phrase_axis_ready;

  modport master (
    output phrase_axis_data, phrase_axis_tuser, phrase_axis_valid,
    input  phrase_axis_ready
  );

  modport slave (
    input  phrase_axis_data, phrase_axis_tuser, phrase_axis_valid,
    output phrase_axis_ready
  );
endinterface

// File: rtl/phrase_skid_fifo.sv
// rtl/phrase_skid_fifo.sv - 2-entry in-order buffer of {tuser, data}
module phrase_skid_fifo
  import ppb_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push,
  input  logic [PHRASE_W:0] din,
  output logic              full,
  input  logic              ready,
  output logic              pop,
  output logic [PHRASE_W:0] dout,
  output logic              empty
);
  logic [PHRASE_W:0] head_q, tail_q;
  logic [1:0]        count_q;
  logic              accept;

  assign empty  = (count_q == 2'd0);
  assign full   = (count_q == 2'd2);
  assign pop    = !empty && ready;
  // A push into a full buffer still lands when the head leaves this cycle.
  assign accept = push && (!full || pop);
  assign dout   = head_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      if (pop && accept) begin
        if (count_q == 2'd1) begin
          head_q <= din;
        end else begin
          head_q <= tail_q;
          tail_q <= din;
        end
      end else if (pop) begin
        head_q  <= tail_q;
        count_q <= count_q - 2'd1;
      end else if (accept) begin
        if (count_q == 2'd0) head_q <= din;
        else                 tail_q <= din;
        count_q <= count_q + 2'd1;
      end
    end
  end
endmodule

// File: rtl/pixel_phrase_builder.sv
// rtl/pixel_phrase_builder.sv - packs RGB565 pixels into 128-bit phrases with SOF on tuser
// Optional build macro PPB_TEST_PATTERN_EN replaces camera data with a column pattern.
module pixel_phrase_builder
  import ppb_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 1280*720,
  parameter int DROP_CNT_W       = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  pixel_valid_in,
  input  logic [PIXEL_W-1:0]    pixel_data_in,
  input  logic                  frame_start_in,
  pixel_phrase_builder_if.master phrase_axis,
  output logic [DROP_CNT_W-1:0] drop_count_out,
  output logic                  overflow_out,
  output logic [1:0]            state_out
);
  localparam int CNT_W = $clog2(PIXELS_PER_FRAME + 1);

  ppb_state_t         state_q, state_d;
  logic [2:0]         slot_q, slot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sof_q, sof_d;
  logic               store, phrase_done;
  logic [PIXEL_W-1:0] pix_q [0:6];

  logic [PIXEL_W-1:0] pix_word;
  logic [2:0]         store_slot;
  logic [PHRASE_W:0]  push_din;
  logic               fifo_full, fifo_pop, fifo_empty, drop;
  logic [PHRASE_W:0]  fifo_dout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= WAIT_SOF;
      slot_q         <= 3'd0;
      cnt_q          <= '0;
      sof_q          <= 1'b0;
      drop_count_out <= '0;
      overflow_out   <= 1'b0;
      for (int k = 0; k < 7; k++) pix_q[k] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      sof_q   <= sof_d;
      if (store && store_slot != 3'd7) pix_q[store_slot] <= pix_word;
      if (drop) begin
        overflow_out <= 1'b1;
        if (drop_count_out != '1) drop_count_out <= drop_count_out + 1'b1;
      end
    end
  end

  // A frame start restarts packing from any state; a partial phrase is simply abandoned.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    sof_d       = sof_q;
    store       = 1'b0;
    phrase_done = 1'b0;
    if (pixel_valid_in) begin
      if (frame_start_in) begin
        state_d = PACK;
        slot_d  = 3'd1;
        cnt_d   = CNT_W'(1);
        sof_d   = 1'b1;
        store   = 1'b1;
      end else if (state_q == PACK) begin
        store  = 1'b1;
        slot_d = slot_q + 3'd1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (slot_q == 3'd7) begin
          phrase_done = 1'b1;
          sof_d       = 1'b0;
        end
        if (cnt_d == CNT_W'(PIXELS_PER_FRAME)) state_d = DONE;
      end
    end
  end

  always_comb begin
    store_slot = frame_start_in ? 3'd0 : slot_q;
`ifdef PPB_TEST_PATTERN_EN
    pix_word = test_pixel(6'((frame_start_in ? '0 : cnt_q) >> 3));
`else
    pix_word = pixel_data_in;
`endif
    push_din = {sof_q, pix_word, {PHRASE_W-PIXEL_W{1'b0}}};
    for (int k = 0; k < 7; k++) push_din[PIXEL_W*k +: PIXEL_W] = pix_q[k];
    drop      = phrase_done && fifo_full && !fifo_pop;
    state_out = state_q;
  end

  phrase_skid_fifo u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (phrase_done),
    .din    (push_din),
    .full   (fifo_full),
    .ready  (phrase_axis.phrase_axis_ready),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty)
  );

  assign phrase_axis.phrase_axis_valid = !fifo_empty;
  assign phrase_axis.phrase_axis_tuser = fifo_dout[PHRASE_W];
  assign phrase_axis.phrase_axis_data  = fifo_dout[PHRASE_W-1:0];
endmodule

// File: tb/tb_pixel_phrase_builder.sv
// tb/tb_pixel_phrase_builder.sv - directed checks of phrase packing, framing and overflow
module tb_pixel_phrase_builder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        pixel_valid_in = 1'b0;
  logic [15:0] pixel_data_in = '0;
  logic        frame_start_in = 1'b0;
  logic [15:0] drop_count_out;
  logic        overflow_out;
  logic [1:0]  state_out;
  int          checks = 0;
  int          errors = 0;
  logic [127:0] got_d[$];
  logic         got_u[$];

  pixel_phrase_builder_if axis ();

  pixel_phrase_builder #(.PIXELS_PER_FRAME(32), .DROP_CNT_W(16)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_data_in  (pixel_data_in),
    .frame_start_in (frame_start_in),
    .phrase_axis    (axis),
    .drop_count_out (drop_count_out),
    .overflow_out   (overflow_out),
    .state_out      (state_out)
  );

  always #5 clk_in = ~clk_in;

  // Handshake is stable half a cycle before the edge that transfers it.
  always @(negedge clk_in) begin
    if (!rst_in && axis.phrase_axis_valid && axis.phrase_axis_ready) begin
      got_d.push_back(axis.phrase_axis_data);
      got_u.push_back(axis.phrase_axis_tuser);
    end
  end

  function automatic logic [127:0] mk(input logic [15:0] base);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input logic fs);
    pixel_valid_in = 1'b1;
    pixel_data_in  = d;
    frame_start_in = fs;
    @(posedge clk_in); #1;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    got_d.delete();
    got_u.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    axis.phrase_axis_ready = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++; if (axis.phrase_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", axis.phrase_axis_valid); end
    checks++; if (axis.phrase_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", axis.phrase_axis_tuser); end
    checks++; if (axis.phrase_axis_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", axis.phrase_axis_data); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_out); end
    checks++; if (drop_count_out !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_single_frame_and_done();
    do_reset();
    axis.phrase_axis_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(16'(i), i == 0);
      if (i == 6) begin
        checks++; if (axis.phrase_axis_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", axis.phrase_axis_valid); end
      end
      if (i == 7) begin
        checks++; if (axis.phrase_axis_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", axis.phrase_axis_valid); end
      end
    end
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL done_state got %0d want 2", state_out); end
    for (int i = 32; i < 40; i++) send(16'(i), 1'b0);
    idle(4);
    checks++; if (got_d.size() !== 4) begin errors++; $display("FAIL frame_count got %0d want 4", got_d.size()); end
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL done_hold got %0d want 2", state_out); end
    checks++; if (got_d[0] !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin errors++; $display("FAIL frame_p0 got %h want %h", got_d[0], mk(16'h0)); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (got_d[j] !== mk(16'(8*j))) begin errors++; $display("FAIL frame_data%0d got %h want %h", j, got_d[j], mk(16'(8*j))); end
      checks++; if (got_u[j] !== (j == 0)) begin errors++; $display("FAIL frame_tuser%0d got %b want %b", j, got_u[j], j == 0); end
    end
  endtask

  task automatic test_junk_before_sof();
    do_reset();
    for (int i = 0; i < 10; i++) send(16'hAAAA, 1'b0);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL junk_state got %0d want 0", state_out); end
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), i == 0);
    idle(3);
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL junk_count got %0d want 1", got_d.size()); end
    checks++; if (got_d[0] !== mk(16'h0100)) begin errors++; $display("FAIL junk_data got %h want %h", got_d[0], mk(16'h0100)); end
    checks++; if (got_u[0] !== 1'b1) begin errors++; $display("FAIL junk_tuser got %b want 1", got_u[0]); end
  endtask

  task automatic test_short_frame();
    do_reset();
    for (int i = 0; i < 5; i++) send(16'h0050 + 16'(i), i == 0);
    for (int i = 0; i < 8; i++) send(16'h0200 + 16'(i), i == 0);
    idle(3);
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL short_count got %0d want 1", got_d.size()); end
    checks++; if (got_d[0] !== mk(16'h0200)) begin errors++; $display("FAIL short_data got %h want %h", got_d[0], mk(16'h0200)); end
    checks++; if (got_u[0] !== 1'b1) begin errors++; $display("FAIL short_tuser got %b want 1", got_u[0]); end
    checks++; if (drop_count_out !== 16'd0) begin errors++; $display("FAIL short_drop got %0d want 0", drop_count_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    axis.phrase_axis_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(16'(i), i == 0);
    idle(1);
    checks++; if (drop_count_out !== 16'd1) begin errors++; $display("FAIL bp_drop got %0d want 1", drop_count_out); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow_out); end
    checks++; if (axis.phrase_axis_data !== mk(16'h0)) begin errors++; $display("FAIL bp_hold got %h want %h", axis.phrase_axis_data, mk(16'h0)); end
    axis.phrase_axis_ready = 1'b1;
    idle(4);
    checks++; if (got_d.size() !== 2) begin errors++; $display("FAIL bp_count got %0d want 2", got_d.size()); end
    checks++; if (got_d[0] !== mk(16'h0) || got_u[0] !== 1'b1) begin errors++; $display("FAIL bp_p0 got %h/%b want %h/1", got_d[0], got_u[0], mk(16'h0)); end
    checks++; if (got_d[1] !== mk(16'h8) || got_u[1] !== 1'b0) begin errors++; $display("FAIL bp_p1 got %h/%b want %h/0", got_d[1], got_u[1], mk(16'h8)); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    axis.phrase_axis_ready = 1'b0;
    for (int i = 0; i < 23; i++) send(16'(i), i == 0);
    axis.phrase_axis_ready = 1'b1;
    send(16'd23, 1'b0);
    axis.phrase_axis_ready = 1'b0;
    checks++; if (drop_count_out !== 16'd0) begin errors++; $display("FAIL pp_drop got %0d want 0", drop_count_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b want 0", overflow_out); end
    checks++; if (axis.phrase_axis_data !== mk(16'h8)) begin errors++; $display("FAIL pp_head got %h want %h", axis.phrase_axis_data, mk(16'h8)); end
    axis.phrase_axis_ready = 1'b1;
    idle(4);
    checks++; if (got_d.size() !== 3) begin errors++; $display("FAIL pp_count got %0d want 3", got_d.size()); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (got_d[j] !== mk(16'(8*j))) begin errors++; $display("FAIL pp_data%0d got %h want %h", j, got_d[j], mk(16'(8*j))); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    axis.phrase_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0777, i == 0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (axis.phrase_axis_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", axis.phrase_axis_valid); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", state_out); end
    rst_in = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0300 + 16'(i), i == 0);
    idle(3);
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL rmid_count got %0d want 1", got_d.size()); end
    checks++; if (got_d[0] !== mk(16'h0300) || got_u[0] !== 1'b1) begin errors++; $display("FAIL rmid_data got %h/%b want %h/1", got_d[0], got_u[0], mk(16'h0300)); end
  endtask

  initial begin
    axis.phrase_axis_ready = 1'b1;
    test_reset();
    test_single_frame_and_done();
    test_junk_before_sof();
    test_short_frame();
    test_backpressure();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
